bus_cache: RTL and testbench
============================

BUS_CACHE -- requirements
Module: bus_cache

Interface
REQ-001 Parameter: INDEX, default 7, number of set-index bits; sets = 2^INDEX.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 clr  in  1  reset, asynchronous, active-low.
REQ-004 stall_in  in  1  pipeline stall; high holds the current access.
REQ-005 addr_in  in  32  next access byte address.
REQ-006 data_in  in  32  write data.
REQ-007 req  in  1  access request valid.
REQ-008 rw  in  1  1 = write, 0 = read.
REQ-009 uncached  in  1  1 = bypass arrays, always go to the bus.
REQ-010 data_out  out  32  read data.
REQ-011 ready  out  1  current access complete.
REQ-012 addr_out  out  32  registered address of the current access.
REQ-013 bus_addr  out  32  bus address; high-Z unless granted.
REQ-014 bus_data  inout  32  bus data; driven only on a granted write, otherwise high-Z.
REQ-015 bus_req  out  1  bus request to arbiter.
REQ-016 bus_rw  out  1  1 = write; high-Z unless granted.
REQ-017 bus_grant  in  1  arbiter grant.
REQ-018 bus_ready  in  1  slave completion strobe.
REQ-019 Debug outputs: we_a, we_b, we_c (1 each), need_update (1), tag (24), hit_a, hit_b (1 each), ram_a_out (32).

Function
REQ-020 Address register loads addr_in, data_in, req, rw and uncached on each edge where stall_in=0; addr_out is this register's address.
REQ-021 Organisation: 2-way set-associative, one 32-bit word per line; index = addr[INDEX+1:2]; tag = addr[31:INDEX+2]; addr[1:0] ignored.
REQ-022 Per way: valid bit, tag, data; per set: one LRU bit naming the way to replace next.
REQ-023 hit_a/hit_b = valid and tag match in way A/B; read hit → ready=1 in the same cycle, data_out = hitting way's data, LRU updated to point at the other way.
REQ-024 Read miss or uncached read: need_update=1; FSM IDLE→REQ (bus_req=1)→on bus_grant XFER (drive bus_addr, bus_rw=0)→on bus_ready capture bus_data→DONE (ready=1 for one cycle)→IDLE.
REQ-025 Fill (cacheable only): write captured word to the LRU way (invalid way preferred, way A first), set valid and tag, flip the LRU bit.
REQ-026 Writes are write-through, no write-allocate: every write goes to the bus via REQ/XFER with bus_rw=1 and bus_data=data registered; on a write hit the hitting way is also updated and the LRU bit is updated; ready on completion.
REQ-027 bus_req deasserts in the cycle after bus_ready; all bus drivers release to Z on return to IDLE.
REQ-028 req=0 → ready=1, no array or bus activity.
REQ-029 we_a/we_b = way A/B write enables; we_c = LRU-bit write enable; tag = low 24 bits of the current tag field; ram_a_out = way A data at current index.
REQ-030 stall_in high during a miss does not abort the miss; the result is held on data_out until the next address load.

Reset
REQ-031 clr low: all valid bits 0, LRU bits 0, FSM IDLE, address register 0 with req=0, bus_req=0, bus drivers Z, ready=1, data_out 0.
REQ-032 clr asserted mid-transaction aborts it immediately; no line is written.

Configuration
REQ-033 Macro BUS_CACHE_DEBUG_EN: defined → debug outputs driven per REQ-029; undefined → all debug outputs constant 0, functional behaviour unchanged.

Verification (INDEX=1)
REQ-034 Read 0 after reset → miss, bus read of 0, fill way A, ready; read 0 again → hit_a, ready same cycle, no bus_req.
REQ-035 Read 0, 8, 16 (same set 0) → 0 in A, 8 in B, 16 replaces 0 (LRU); read 0 → miss, replaces 8.
REQ-036 Read 0, 8, read 0 (hit) then 16 → 16 replaces 8, not 0.
REQ-037 Write 0xab21128 to 24 (miss) → bus write, no fill; read 24 → miss, returns 0xab21128 from the slave.
REQ-038 bus_grant withheld 5 cycles on a miss → bus_req held, bus_addr Z, ready=0 until grant plus bus_ready.
REQ-039 clr pulsed low during XFER → bus_req 0 and bus lines Z immediately; subsequent read of the same address misses.

Source files
------------

// File: rtl/bus_cache.sv
// rtl/bus_cache.sv - 2-way set-associative write-through cache with a tri-state bus master port
// Optional debug outputs: define BUS_CACHE_DEBUG_EN to drive we_a/we_b/we_c/need_update/tag/hit_a/hit_b/ram_a_out.
module bus_cache #(
   parameter int INDEX = 7
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        stall_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] data_in,
   input  logic        req,
   input  logic        rw,
   input  logic        uncached,
   output logic [31:0] data_out,
   output logic        ready,
   output logic [31:0] addr_out,
   output wire  [31:0] bus_addr,
   inout  wire  [31:0] bus_data,
   output logic        bus_req,
   output wire         bus_rw,
   input  logic        bus_grant,
   input  logic        bus_ready,
   output logic        we_a,
   output logic        we_b,
   output logic        we_c,
   output logic        need_update,
   output logic [23:0] tag,
   output logic        hit_a,
   output logic        hit_b,
   output logic [31:0] ram_a_out
);

   localparam int SETS = 1 << INDEX;
   localparam int TW   = 30 - INDEX;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

   state_t            state_q, state_d;

   // CPU-side address register
   logic [31:0]       addr_q, data_q;
   logic              req_q, rw_q, unc_q;
   // access already completed by the bus path; keeps ready/data_out stable while stalled
   logic              served_q;

   // bus transaction copy, so the miss survives further address loads
   logic [31:0]       pend_addr_q, pend_data_q;
   logic              pend_rw_q, pend_unc_q;
   logic [31:0]       rdata_q;

   // arrays
   logic [SETS-1:0]   valid_a_q, valid_b_q, lru_q;
   logic [TW-1:0]     tag_a_q  [SETS];
   logic [TW-1:0]     tag_b_q  [SETS];
   logic [31:0]       data_a_q [SETS];
   logic [31:0]       data_b_q [SETS];

   logic [INDEX-1:0]  look_idx;
   logic [TW-1:0]     look_tag;
   logic              way_a_hit, way_b_hit, any_hit;
   logic              active, rd_hit, start, miss_rd;
   logic              done_c, fill, wr_hit, victim_b;
   logic              wen_a, wen_b, lru_we, lru_new;
   logic [31:0]       wdata, hit_data;
   logic              drive;

   // the CPU access is looked up while idle, the pending bus access otherwise
   assign look_idx  = (state_q == S_IDLE) ? addr_q[INDEX+1:2]  : pend_addr_q[INDEX+1:2];
   assign look_tag  = (state_q == S_IDLE) ? addr_q[31:INDEX+2] : pend_addr_q[31:INDEX+2];
   assign way_a_hit = valid_a_q[look_idx] && (tag_a_q[look_idx] == look_tag);
   assign way_b_hit = valid_b_q[look_idx] && (tag_b_q[look_idx] == look_tag);
   assign any_hit   = way_a_hit || way_b_hit;
   assign hit_data  = way_a_hit ? data_a_q[look_idx] : data_b_q[look_idx];

   assign active  = (state_q == S_IDLE) && req_q && !served_q;
   assign rd_hit  = active && !rw_q && !unc_q && any_hit;
   assign miss_rd = active && !rw_q && (unc_q || !any_hit);
   assign start   = active && (rw_q || unc_q || !any_hit);

   // array updates all happen in DONE: fills on cacheable reads, write-through updates on write hits
   assign done_c   = (state_q == S_DONE) && !pend_unc_q;
   assign fill     = done_c && !pend_rw_q;
   assign wr_hit   = done_c && pend_rw_q && any_hit;
   assign victim_b = valid_a_q[look_idx] && (!valid_b_q[look_idx] || lru_q[look_idx]);
   assign wen_a    = (fill && !victim_b) || (wr_hit && way_a_hit);
   assign wen_b    = (fill && victim_b) || (wr_hit && way_b_hit);
   assign wdata    = fill ? rdata_q : pend_data_q;
   assign lru_we   = rd_hit || fill || wr_hit;
   // LRU names the way to replace next: the one not just used
   assign lru_new  = fill ? !victim_b : way_a_hit;

   assign addr_out = addr_q;
   assign data_out = rd_hit ? hit_data : rdata_q;

   assign bus_addr = drive ? pend_addr_q : 32'bz;
   assign bus_rw   = drive ? pend_rw_q : 1'bz;
   assign bus_data = (drive && pend_rw_q) ? pend_data_q : 32'bz;

   // address register, loaded whenever the pipeline is not stalled
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         addr_q   <= '0;
         data_q   <= '0;
         req_q    <= 1'b0;
         rw_q     <= 1'b0;
         unc_q    <= 1'b0;
         served_q <= 1'b0;
      end else if (!stall_in) begin
         addr_q   <= addr_in;
         data_q   <= data_in;
         req_q    <= req;
         rw_q     <= rw;
         unc_q    <= uncached;
         served_q <= 1'b0;
      end else if (state_q == S_DONE) begin
         served_q <= 1'b1;
      end
   end

   // capture the access being sent to the bus, and read data returned by the slave
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         pend_addr_q <= '0;
         pend_data_q <= '0;
         pend_rw_q   <= 1'b0;
         pend_unc_q  <= 1'b0;
         rdata_q     <= '0;
      end else begin
         if (start) begin
            pend_addr_q <= addr_q;
            pend_data_q <= data_q;
            pend_rw_q   <= rw_q;
            pend_unc_q  <= unc_q;
         end
         if ((state_q == S_XFER) && bus_ready && !pend_rw_q) begin
            rdata_q <= bus_data;
         end
      end
   end

   // valid and LRU bits, cleared by reset
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         valid_a_q <= '0;
         valid_b_q <= '0;
         lru_q     <= '0;
      end else begin
         if (wen_a) valid_a_q[look_idx] <= 1'b1;
         if (wen_b) valid_b_q[look_idx] <= 1'b1;
         if (lru_we) lru_q[look_idx] <= lru_new;
      end
   end

   // tag and data storage, qualified by the valid bits so no reset needed
   always_ff @(posedge clk) begin
      if (wen_a) begin
         tag_a_q[look_idx]  <= look_tag;
         data_a_q[look_idx] <= wdata;
      end
      if (wen_b) begin
         tag_b_q[look_idx]  <= look_tag;
         data_b_q[look_idx] <= wdata;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_REQ;
         S_REQ:   if (bus_grant) state_d = S_XFER;
         S_XFER:  if (bus_ready) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: bus request, bus drive enable, access complete
   always_comb begin
      bus_req = 1'b0;
      drive   = 1'b0;
      ready   = 1'b0;
      case (state_q)
         S_IDLE:  ready = !req_q || served_q || rd_hit;
         S_REQ:   bus_req = 1'b1;
         S_XFER: begin
            bus_req = 1'b1;
            drive   = 1'b1;
         end
         S_DONE:  ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

`ifdef BUS_CACHE_DEBUG_EN
   logic [31:0] tag_ext;
   assign tag_ext     = {{(INDEX + 2){1'b0}}, look_tag};
   assign we_a        = wen_a;
   assign we_b        = wen_b;
   assign we_c        = lru_we;
   assign need_update = miss_rd;
   assign tag         = tag_ext[23:0];
   assign hit_a       = way_a_hit;
   assign hit_b       = way_b_hit;
   assign ram_a_out   = data_a_q[look_idx];
`else
   logic unused_dbg;
   assign unused_dbg  = miss_rd;
   assign we_a        = 1'b0;
   assign we_b        = 1'b0;
   assign we_c        = 1'b0;
   assign need_update = 1'b0;
   assign tag         = '0;
   assign hit_a       = 1'b0;
   assign hit_b       = 1'b0;
   assign ram_a_out   = '0;
`endif

endmodule

// File: tb/tb_bus_cache.sv
// tb/tb_bus_cache.sv - directed scoreboard bench for bus_cache (INDEX=1)
module tb_bus_cache;

   logic        clk = 1'b0;
   logic        clr, stall_in, req, rw, uncached, bus_grant, bus_ready;
   logic [31:0] addr_in, data_in;
   logic [31:0] data_out, addr_out, ram_a_out;
   logic        ready, bus_req;
   logic        we_a, we_b, we_c, need_update, hit_a, hit_b;
   logic [23:0] tag;
   wire  [31:0] bus_addr, bus_data;
   wire         bus_rw;

   logic        slave_en;
   logic [31:0] slave_word;
   assign bus_data = slave_en ? slave_word : 32'bz;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] sb_q[$];
   logic [31:0] mem [logic [31:0]];

   bus_cache #(.INDEX(1)) dut (
      .clk(clk), .clr(clr), .stall_in(stall_in), .addr_in(addr_in), .data_in(data_in),
      .req(req), .rw(rw), .uncached(uncached), .data_out(data_out), .ready(ready),
      .addr_out(addr_out), .bus_addr(bus_addr), .bus_data(bus_data), .bus_req(bus_req),
      .bus_rw(bus_rw), .bus_grant(bus_grant), .bus_ready(bus_ready),
      .we_a(we_a), .we_b(we_b), .we_c(we_c), .need_update(need_update), .tag(tag),
      .hit_a(hit_a), .hit_b(hit_b), .ram_a_out(ram_a_out)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] wadr(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   // slave memory: unwritten words read back as a recognisable pattern
   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(wadr(a))) return mem[wadr(a)];
      return {16'hc0de, a[15:2], 2'b00};
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic unc, input logic exp_miss, input int gdly,
                         input logic [31:0] exp_rd);
      logic [31:0] exp_v;
      int          waited;
      addr_in  = a;
      data_in  = d;
      rw       = w;
      uncached = unc;
      req      = 1'b1;
      stall_in = 1'b0;
      if (!w) sb_q.push_back(exp_rd);
      @(negedge clk);
      stall_in = 1'b1;
      if (!exp_miss) begin
         chk("hit_ready", 32'(ready), 32'd1);
         chk("hit_no_bus_req", 32'(bus_req), 32'd0);
         exp_v = sb_q.pop_front();
         chk("hit_data", data_out, exp_v);
`ifdef BUS_CACHE_DEBUG_EN
         chk("dbg_hit", 32'(hit_a | hit_b), 32'd1);
`else
         chk("dbg_hit_quiet", {30'd0, hit_a, hit_b}, 32'd0);
`endif
      end else begin
         chk("miss_ready_low", 32'(ready), 32'd0);
         @(negedge clk);
         waited = 0;
         while (bus_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
         end
         chk("bus_req_raised", 32'(bus_req), 32'd1);
         for (int i = 0; i < gdly; i++) begin
            chk("wait_grant_ready", 32'(ready), 32'd0);
            chk("wait_grant_req", 32'(bus_req), 32'd1);
            if (a != 0) chk("wait_grant_addr_released", 32'(bus_addr !== a), 32'd1);
            @(negedge clk);
         end
         bus_grant = 1'b1;
         @(negedge clk);
         chk("xfer_addr", bus_addr, a);
         chk("xfer_rw", 32'(bus_rw), 32'(w));
         chk("xfer_req", 32'(bus_req), 32'd1);
         chk("xfer_ready_low", 32'(ready), 32'd0);
         if (w) begin
            chk("xfer_wdata", bus_data, d);
            mem[wadr(a)] = d;
         end else begin
            slave_word = mem_rd(a);
            slave_en   = 1'b1;
         end
         bus_ready = 1'b1;
         @(negedge clk);
         bus_ready = 1'b0;
         bus_grant = 1'b0;
         slave_en  = 1'b0;
         chk("done_ready", 32'(ready), 32'd1);
         chk("done_req_dropped", 32'(bus_req), 32'd0);
         if (a != 0) chk("done_addr_released", 32'(bus_addr !== a), 32'd1);
         if (!w) begin
            exp_v = sb_q.pop_front();
            chk("done_data", data_out, exp_v);
         end
         @(negedge clk);
         chk("held_ready", 32'(ready), 32'd1);
         chk("held_no_req", 32'(bus_req), 32'd0);
         if (!w) chk("held_data", data_out, exp_v);
      end
   endtask

   initial begin
      clr = 1'b0; stall_in = 1'b0; req = 1'b0; rw = 1'b0; uncached = 1'b0;
      bus_grant = 1'b0; bus_ready = 1'b0; addr_in = '0; data_in = '0;
      slave_en = 1'b0; slave_word = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_data_out", data_out, 32'd0);
      chk("rst_addr_out", addr_out, 32'd0);
      clr = 1'b1;

      // no request: ready, no bus activity
      addr_in = 32'h4;
      @(negedge clk);
      chk("idle_addr_out", addr_out, 32'h4);
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_bus_req", 32'(bus_req), 32'd0);
      @(negedge clk);
      chk("idle_bus_req2", 32'(bus_req), 32'd0);

      // first read misses and fills, second hits
      access(1'b0, 32'd0,  '0, 1'b0, 1'b1, 0, mem_rd(0));
      access(1'b0, 32'd0,  '0, 1'b0, 1'b0, 0, mem_rd(0));

      // set 0 replacement: 0 in A, 8 in B, 16 evicts 0, 0 evicts 8
      access(1'b0, 32'd8,  '0, 1'b0, 1'b1, 0, mem_rd(8));
      access(1'b0, 32'd16, '0, 1'b0, 1'b1, 0, mem_rd(16));
      access(1'b0, 32'd0,  '0, 1'b0, 1'b1, 0, mem_rd(0));
      access(1'b0, 32'd16, '0, 1'b0, 1'b0, 0, mem_rd(16));
      access(1'b0, 32'd0,  '0, 1'b0, 1'b0, 0, mem_rd(0));
      access(1'b0, 32'd8,  '0, 1'b0, 1'b1, 0, mem_rd(8));

      // set 1: a hit on 4 makes 20 evict 12 rather than 4
      access(1'b0, 32'd4,  '0, 1'b0, 1'b1, 0, mem_rd(4));
      access(1'b0, 32'd12, '0, 1'b0, 1'b1, 0, mem_rd(12));
      access(1'b0, 32'd4,  '0, 1'b0, 1'b0, 0, mem_rd(4));
      access(1'b0, 32'd20, '0, 1'b0, 1'b1, 0, mem_rd(20));
      access(1'b0, 32'd4,  '0, 1'b0, 1'b0, 0, mem_rd(4));
      access(1'b0, 32'd12, '0, 1'b0, 1'b1, 0, mem_rd(12));

      // write miss goes to the bus without allocating
      access(1'b1, 32'd24, 32'h0ab21128, 1'b0, 1'b1, 0, '0);
      access(1'b0, 32'd24, '0, 1'b0, 1'b1, 0, 32'h0ab21128);
      access(1'b0, 32'd24, '0, 1'b0, 1'b0, 0, 32'h0ab21128);

      // write hit updates the line as well as the bus
      access(1'b1, 32'd8,  32'h12345678, 1'b0, 1'b1, 0, '0);
      access(1'b0, 32'd8,  '0, 1'b0, 1'b0, 0, 32'h12345678);

      // uncached accesses bypass the arrays
      access(1'b0, 32'd8,  '0, 1'b1, 1'b1, 0, 32'h12345678);
      access(1'b1, 32'd24, 32'hdeadbeef, 1'b1, 1'b1, 0, '0);
      access(1'b0, 32'd24, '0, 1'b0, 1'b0, 0, 32'h0ab21128);

      // grant withheld for 5 cycles
      access(1'b0, 32'd32, '0, 1'b0, 1'b1, 5, mem_rd(32));

      // reset in the middle of a bus read
      addr_in = 32'd40; data_in = '0; rw = 1'b0; uncached = 1'b0; req = 1'b1; stall_in = 1'b0;
      @(negedge clk);
      stall_in = 1'b1;
      @(negedge clk);
      bus_grant = 1'b1;
      @(negedge clk);
      chk("abort_xfer_addr", bus_addr, 32'd40);
      clr = 1'b0;
      #1;
      chk("abort_bus_req", 32'(bus_req), 32'd0);
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_addr_released", 32'(bus_addr !== 32'd40), 32'd1);
      chk("abort_data_out", data_out, 32'd0);
      chk("abort_addr_out", addr_out, 32'd0);
      bus_grant = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      access(1'b0, 32'd40, '0, 1'b0, 1'b1, 0, mem_rd(40));
      access(1'b0, 32'd40, '0, 1'b0, 1'b0, 0, mem_rd(40));

      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
